// File: rtl/corevx_bus_arbiter.sv
// rtl/corevx_bus_arbiter.sv - round-robin arbiter sharing one armleobus master port among N requesters
module corevx_bus_arbiter #(
    parameter int N   = 2,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      r_transaction,
    input  logic [3*N-1:0]    r_cmd,
    input  logic [34*N-1:0]   r_address,
    input  logic [32*N-1:0]   r_wdata,
    input  logic [4*N-1:0]    r_wbyte_enable,
    output logic [N-1:0]      r_transaction_done,
    output logic [2:0]        r_transaction_response,
    output logic [31:0]       r_rdata,
    output logic              m_transaction,
    output logic [2:0]        m_cmd,
    output logic [33:0]       m_address,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wbyte_enable,
    input  logic [2:0]        m_transaction_response,
    input  logic              m_transaction_done,
    input  logic [31:0]       m_rdata,
    output logic              grant_valid,
    output logic [IDW-1:0]    grant_id
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

    logic [0:0]     state_q, state_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [IDW-1:0] prio_q, prio_d;
    logic [IDW-1:0] pick_id;
    logic           pick_found;
    logic           busy;
    int             idx;

    assign busy = (state_q == ST_BUSY);

    // Search order starts at prio and wraps modulo N, so N need not be a power of two.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(prio_q) + k) % N;
            if (!pick_found && r_transaction[idx]) begin
                pick_found = 1'b1;
                pick_id    = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        prio_d     = prio_q;
        if (!busy) begin
            if (pick_found) begin
                state_d    = ST_BUSY;
                grant_id_d = pick_id;
            end
        end else if (m_transaction_done) begin
            state_d = ST_IDLE;
            prio_d  = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            prio_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            prio_q     <= prio_d;
        end
    end

    // Done is gated by rst_n so a completion landing on the reset edge is never forwarded.
    always_comb begin
        r_transaction_done = '0;
        m_cmd              = '0;
        m_address          = '0;
        m_wdata            = '0;
        m_wbyte_enable     = '0;
        for (int i = 0; i < N; i++) begin
            if (busy && grant_id_q == IDW'(i)) begin
                m_cmd                 = r_cmd[3*i +: 3];
                m_address             = r_address[34*i +: 34];
                m_wdata               = r_wdata[32*i +: 32];
                m_wbyte_enable        = r_wbyte_enable[4*i +: 4];
                r_transaction_done[i] = m_transaction_done && rst_n;
            end
        end
    end

    assign m_transaction          = busy;
    assign grant_valid            = busy;
    assign grant_id               = grant_id_q;
    assign r_transaction_response = m_transaction_response;
    assign r_rdata                = m_rdata;

endmodule

// File: tb/tb_corevx_bus_arbiter.sv
// tb/tb_corevx_bus_arbiter.sv - table-driven bench for corevx_bus_arbiter (N=2 and N=3 instances)
module tb_corevx_bus_arbiter;

    localparam logic [33:0] A0 = 34'h0_1000_0000;
    localparam logic [33:0] A1 = 34'h2_2000_0004;
    localparam logic [2:0]  C0 = 3'd1;
    localparam logic [2:0]  C1 = 3'd2;
    localparam logic [3:0]  B0 = 4'hF;
    localparam logic [3:0]  B1 = 4'h3;
    localparam logic [33:0] T0 = 34'h0_0000_0100;
    localparam logic [33:0] T1 = 34'h1_0000_0200;
    localparam logic [33:0] T2 = 34'h3_0000_0300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rt2;
    logic        md2;
    logic [2:0]  mr2;
    logic [31:0] rd2;
    logic [1:0]  rdone2;
    logic [2:0]  rresp2;
    logic [31:0] rrdata2;
    logic        mt2, gv2;
    logic [2:0]  mcmd2;
    logic [33:0] maddr2;
    logic [31:0] mwdata2;
    logic [3:0]  mbe2;
    logic [0:0]  gid2;

    corevx_bus_arbiter #(.N(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .r_transaction(rt2), .r_cmd({C1, C0}), .r_address({A1, A0}),
        .r_wdata({32'h2222_2222, 32'h1111_1111}), .r_wbyte_enable({B1, B0}),
        .r_transaction_done(rdone2), .r_transaction_response(rresp2), .r_rdata(rrdata2),
        .m_transaction(mt2), .m_cmd(mcmd2), .m_address(maddr2), .m_wdata(mwdata2),
        .m_wbyte_enable(mbe2), .m_transaction_response(mr2), .m_transaction_done(md2),
        .m_rdata(rd2), .grant_valid(gv2), .grant_id(gid2)
    );

    logic [2:0]  rt3;
    logic        md3;
    logic [2:0]  rdone3;
    logic [2:0]  rresp3;
    logic [31:0] rrdata3;
    logic        mt3, gv3;
    logic [2:0]  mcmd3;
    logic [33:0] maddr3;
    logic [31:0] mwdata3;
    logic [3:0]  mbe3;
    logic [1:0]  gid3;

    corevx_bus_arbiter #(.N(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .r_transaction(rt3), .r_cmd(9'b011_010_001), .r_address({T2, T1, T0}),
        .r_wdata({32'h3, 32'h2, 32'h1}), .r_wbyte_enable(12'hC31),
        .r_transaction_done(rdone3), .r_transaction_response(rresp3), .r_rdata(rrdata3),
        .m_transaction(mt3), .m_cmd(mcmd3), .m_address(maddr3), .m_wdata(mwdata3),
        .m_wbyte_enable(mbe3), .m_transaction_response(3'd0), .m_transaction_done(md3),
        .m_rdata(32'h0), .grant_valid(gv3), .grant_id(gid3)
    );

    typedef struct {
        logic        rn;
        logic [1:0]  rt;
        logic        md;
        logic [2:0]  mr;
        logic [31:0] rd;
        logic        em;
        logic        eg;
        logic [1:0]  edn;
    } vec_t;

    vec_t vecs[32];
    int   nv = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic rn, input logic [1:0] rt, input logic md, input logic [2:0] mr,
                       input logic [31:0] rd, input logic em, input logic eg, input logic [1:0] edn);
        vecs[nv] = '{rn, rt, md, mr, rd, em, eg, edn};
        nv++;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        rt2 = '0; md2 = 1'b0; mr2 = '0; rd2 = '0;
        rt3 = '0; md3 = 1'b0;

        // cycle-by-cycle vectors for the N=2 instance
        add(1, 2'b10, 0, 3'd0, 32'h0,         0, 0, 2'b00); // single request from 1
        add(1, 2'b10, 0, 3'd0, 32'h0,         1, 1, 2'b00);
        add(1, 2'b10, 0, 3'd0, 32'h0,         1, 1, 2'b00);
        add(1, 2'b10, 1, 3'd0, 32'hDEADBEEF,  1, 1, 2'b10);
        add(1, 2'b00, 0, 3'd0, 32'h0,         0, 1, 2'b00);
        add(1, 2'b11, 0, 3'd0, 32'h0,         0, 1, 2'b00); // both request, prio 0
        add(1, 2'b11, 1, 3'd0, 32'hAAAA0001,  1, 0, 2'b01);
        add(1, 2'b11, 0, 3'd0, 32'h0,         0, 0, 2'b00);
        add(1, 2'b11, 1, 3'd5, 32'hBBBB0002,  1, 1, 2'b10); // error code passes through
        add(1, 2'b11, 0, 3'd0, 32'h0,         0, 1, 2'b00);
        add(1, 2'b11, 1, 3'd7, 32'h12345678,  1, 0, 2'b01);
        add(1, 2'b11, 0, 3'd0, 32'h0,         0, 0, 2'b00);
        add(1, 2'b11, 0, 3'd0, 32'h0,         1, 1, 2'b00);
        add(1, 2'b11, 1, 3'd0, 32'hCCCC0003,  1, 1, 2'b10);
        add(1, 2'b00, 1, 3'd0, 32'h0,         0, 1, 2'b00); // stray done in IDLE
        add(1, 2'b00, 1, 3'd0, 32'h0,         0, 1, 2'b00);
        add(1, 2'b11, 0, 3'd0, 32'h0,         0, 1, 2'b00); // prio still 0 -> grant 0
        add(1, 2'b11, 1, 3'd2, 32'hDDDD0004,  1, 0, 2'b01);
        add(1, 2'b10, 0, 3'd0, 32'h0,         0, 0, 2'b00);
        add(1, 2'b10, 0, 3'd0, 32'h0,         1, 1, 2'b00);
        add(0, 2'b10, 1, 3'd0, 32'hEEEE0005,  1, 1, 2'b00); // reset mid-BUSY
        add(1, 2'b10, 0, 3'd0, 32'h0,         0, 0, 2'b00);
        add(1, 2'b10, 1, 3'd0, 32'hF0F0F0F0,  1, 1, 2'b10);
        add(1, 2'b00, 0, 3'd0, 32'h0,         0, 1, 2'b00);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_mt2", 64'(mt2), 64'd0);
        chk("reset_gv2", 64'(gv2), 64'd0);
        chk("reset_gid2", 64'(gid2), 64'd0);
        chk("reset_addr2", 64'(maddr2), 64'd0);
        chk("reset_done2", 64'(rdone2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < nv; i++) begin
            logic [33:0] ea;
            logic [3:0]  eb;
            logic [2:0]  ec;
            @(negedge clk);
            rst_n = vecs[i].rn;
            rt2   = vecs[i].rt;
            md2   = vecs[i].md;
            mr2   = vecs[i].mr;
            rd2   = vecs[i].rd;
            #1;
            ea = !vecs[i].em ? 34'h0 : (vecs[i].eg ? A1 : A0);
            eb = !vecs[i].em ? 4'h0  : (vecs[i].eg ? B1 : B0);
            ec = !vecs[i].em ? 3'd0  : (vecs[i].eg ? C1 : C0);
            chk($sformatf("v%0d_mt", i),   64'(mt2),    64'(vecs[i].em));
            chk($sformatf("v%0d_gv", i),   64'(gv2),    64'(vecs[i].em));
            chk($sformatf("v%0d_gid", i),  64'(gid2),   64'(vecs[i].eg));
            chk($sformatf("v%0d_done", i), 64'(rdone2), 64'(vecs[i].edn));
            chk($sformatf("v%0d_addr", i), 64'(maddr2), 64'(ea));
            chk($sformatf("v%0d_be", i),   64'(mbe2),   64'(eb));
            chk($sformatf("v%0d_cmd", i),  64'(mcmd2),  64'(ec));
            if (vecs[i].edn != 2'b00) begin
                chk($sformatf("v%0d_rdata", i), 64'(rrdata2), 64'(vecs[i].rd));
                chk($sformatf("v%0d_resp", i),  64'(rresp2),  64'(vecs[i].mr));
            end
        end
        rt2 = '0; md2 = 1'b0;

        // N=3 wrap: grant 2, complete, then 3'b011 must go 0 then 1
        @(negedge clk); rt3 = 3'b100; #1;
        chk("w3_idle_mt", 64'(mt3), 64'd0);
        @(negedge clk); #1;
        chk("w3_gid2", 64'(gid3), 64'd2);
        chk("w3_addr2", 64'(maddr3), 64'(T2));
        @(negedge clk); md3 = 1'b1; #1;
        chk("w3_done2", 64'(rdone3), 64'b100);
        @(negedge clk); md3 = 1'b0; rt3 = 3'b011; #1;
        chk("w3_gap_mt", 64'(mt3), 64'd0);
        @(negedge clk); #1;
        chk("w3_gid0", 64'(gid3), 64'd0);
        chk("w3_addr0", 64'(maddr3), 64'(T0));
        @(negedge clk); md3 = 1'b1; #1;
        chk("w3_done0", 64'(rdone3), 64'b001);
        @(negedge clk); md3 = 1'b0; #1;
        chk("w3_gap2_mt", 64'(mt3), 64'd0);
        @(negedge clk); #1;
        chk("w3_gid1", 64'(gid3), 64'd1);
        chk("w3_be1", 64'(mbe3), 64'h3);
        @(negedge clk); md3 = 1'b1; #1;
        chk("w3_done1", 64'(rdone3), 64'b010);
        @(negedge clk); md3 = 1'b0; rt3 = 3'b000;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
